// File: rtl/hazard_fwd_ctrl.sv
// Load-use hazard detection and operand forwarding control for a 5-stage pipeline.
// Shadows the destination fields of EXE/MEM/WB and registers the EXE operand selects.
module hazard_fwd_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ID_Valid,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        ID_UseRs,
   input  logic        ID_UseRt,
   input  logic [4:0]  ID_Rw,
   input  logic        ID_RegWr,
   input  logic        ID_MemtoReg,
   input  logic        Flush,
   output logic [1:0]  FwdA,
   output logic [1:0]  FwdB,
   output logic        Stall,
   output logic        EX_Bubble,
   output logic [15:0] StallCnt
);

   typedef struct packed {
      logic       valid;
      logic       regWr;
      logic       memtoReg;
      logic [4:0] rw;
   } shadowT;

   localparam logic [1:0] SelMem = 2'b00;
   localparam logic [1:0] SelWb  = 2'b01;
   localparam logic [1:0] SelReg = 2'b10;
   localparam shadowT     EmptyEntry = '0;

   shadowT     exeEntry;
   shadowT     memEntry;
   shadowT     wbEntry;
   shadowT     exeNext;
   logic       exeProducer;
   logic       loadUse;
   logic       bubbleIn;
   logic [1:0] fwdANext;
   logic [1:0] fwdBNext;
   logic       unusedWb;

   function automatic logic isProducer(input shadowT e);
      return e.valid && e.regWr && (e.rw != 5'd0);
   endfunction

   // The nearer (EXE) producer wins over MEM; WB is never a source because the register file is write-first.
   function automatic logic [1:0] selectSrc(input logic readsReg, input logic [4:0] src,
                                            input logic bubble, input shadowT exe, input shadowT mem);
      if (bubble || !readsReg)
         return SelReg;
      else if (isProducer(exe) && (exe.rw == src))
         return SelMem;
      else if (isProducer(mem) && (mem.rw == src))
         return SelWb;
      else
         return SelReg;
   endfunction

   // Hazard detection, bubble insertion and next operand selects.
   always_comb begin
      exeProducer = isProducer(exeEntry);
      loadUse     = 1'b0;
      if (!rst && ID_Valid && !Flush && exeProducer && exeEntry.memtoReg) begin
         loadUse = (ID_UseRs && (ID_Rs == exeEntry.rw)) ||
                   (ID_UseRt && (ID_Rt == exeEntry.rw));
      end
      Stall    = loadUse;
      bubbleIn = loadUse || Flush || !ID_Valid;

      exeNext = EmptyEntry;
      if (!bubbleIn) begin
         exeNext.valid    = 1'b1;
         exeNext.regWr    = ID_RegWr;
         exeNext.memtoReg = ID_MemtoReg;
         exeNext.rw       = ID_Rw;
      end

      fwdANext = selectSrc(ID_UseRs, ID_Rs, bubbleIn, exeEntry, memEntry);
      fwdBNext = selectSrc(ID_UseRt, ID_Rt, bubbleIn, exeEntry, memEntry);
   end

   // Shadow pipeline, registered selects and the saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         exeEntry  <= EmptyEntry;
         memEntry  <= EmptyEntry;
         wbEntry   <= EmptyEntry;
         FwdA      <= SelReg;
         FwdB      <= SelReg;
         EX_Bubble <= 1'b1;
         StallCnt  <= 16'd0;
      end else begin
         wbEntry   <= memEntry;
         memEntry  <= exeEntry;
         exeEntry  <= exeNext;
         FwdA      <= fwdANext;
         FwdB      <= fwdBNext;
         EX_Bubble <= !exeNext.valid;
         if (Stall && (StallCnt != 16'hFFFF))
            StallCnt <= StallCnt + 16'd1;
      end
   end

   // The WB shadow is kept for completeness but feeds no forwarding path.
   assign unusedWb = ^wbEntry;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scenario bench for hazard_fwd_ctrl: expected selects/stall/counter are queued as each
// instruction is presented and compared once the DUT has clocked it into EXE.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ID_Valid;
   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic        ID_UseRs;
   logic        ID_UseRt;
   logic [4:0]  ID_Rw;
   logic        ID_RegWr;
   logic        ID_MemtoReg;
   logic        Flush;
   logic [1:0]  FwdA;
   logic [1:0]  FwdB;
   logic        Stall;
   logic        EX_Bubble;
   logic [15:0] StallCnt;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       useRs;
      logic       useRt;
      logic [4:0] rw;
      logic       regWr;
      logic       memtoReg;
      logic       flush;
      logic       rst;
   } stimT;

   typedef struct {
      string       name;
      logic        stall;
      logic [1:0]  fwdA;
      logic [1:0]  fwdB;
      logic        bubble;
      logic [15:0] cnt;
   } expT;

   expT sb[$];

   hazard_fwd_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ID_Valid    (ID_Valid),
      .ID_Rs       (ID_Rs),
      .ID_Rt       (ID_Rt),
      .ID_UseRs    (ID_UseRs),
      .ID_UseRt    (ID_UseRt),
      .ID_Rw       (ID_Rw),
      .ID_RegWr    (ID_RegWr),
      .ID_MemtoReg (ID_MemtoReg),
      .Flush       (Flush),
      .FwdA        (FwdA),
      .FwdB        (FwdB),
      .Stall       (Stall),
      .EX_Bubble   (EX_Bubble),
      .StallCnt    (StallCnt)
   );

   always #5 clk = ~clk;

   function automatic stimT idleOp();
      stimT s;
      s = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, useRs: 1'b0, useRt: 1'b0, rw: 5'd0,
            regWr: 1'b0, memtoReg: 1'b0, flush: 1'b0, rst: 1'b0};
      return s;
   endfunction

   function automatic stimT aluOp(input int rd, input int rs, input int rt);
      stimT s = idleOp();
      s.valid = 1'b1; s.rs = 5'(rs); s.rt = 5'(rt); s.useRs = 1'b1; s.useRt = 1'b1;
      s.rw = 5'(rd); s.regWr = 1'b1;
      return s;
   endfunction

   function automatic stimT immOp(input int rt, input int rs);
      stimT s = idleOp();
      s.valid = 1'b1; s.rs = 5'(rs); s.rt = 5'(rt); s.useRs = 1'b1;
      s.rw = 5'(rt); s.regWr = 1'b1;
      return s;
   endfunction

   function automatic stimT loadOp(input int rt, input int base);
      stimT s = immOp(rt, base);
      s.memtoReg = 1'b1;
      return s;
   endfunction

   function automatic stimT storeOp(input int rt, input int base);
      stimT s = idleOp();
      s.valid = 1'b1; s.rs = 5'(base); s.rt = 5'(rt); s.useRs = 1'b1; s.useRt = 1'b1;
      return s;
   endfunction

   function automatic expT ex(input string name, input logic stall, input logic [1:0] a,
                              input logic [1:0] b, input logic bub, input int cnt);
      expT e;
      e = '{name: name, stall: stall, fwdA: a, fwdB: b, bubble: bub, cnt: 16'(cnt)};
      return e;
   endfunction

   task automatic applyStimulus(input stimT s);
      rst         = s.rst;
      ID_Valid    = s.valid;
      ID_Rs       = s.rs;
      ID_Rt       = s.rt;
      ID_UseRs    = s.useRs;
      ID_UseRt    = s.useRt;
      ID_Rw       = s.rw;
      ID_RegWr    = s.regWr;
      ID_MemtoReg = s.memtoReg;
      Flush       = s.flush;
   endtask

   task automatic doReset();
      stimT s = idleOp();
      s.rst = 1'b1;
      applyStimulus(s);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      stimT st[$];
      expT  e;
      stimT s;
      s = loadOp(2, 1); s.rst = 1'b1;
      st.push_back(s);             sb.push_back(ex("reset0", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(s);             sb.push_back(ex("reset1", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(aluOp(3,2,2));  sb.push_back(ex("postReset", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(aluOp(4,3,2));  sb.push_back(ex("postResetFwd", 0, 2'b00, 2'b10, 0, 0));
      st.push_back(idleOp());      sb.push_back(ex("postResetIdle", 0, 2'b10, 2'b10, 1, 0));
      foreach (st[k]) begin
         applyStimulus(st[k]);
         @(negedge clk);
         testsRun++;
         if (Stall !== sb[0].stall) begin
            testsFailed++;
            $display("[TB] FAIL %s stall: got %b expected %b", sb[0].name, Stall, sb[0].stall);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         testsRun++;
         if ({FwdA, FwdB, EX_Bubble, StallCnt} !== {e.fwdA, e.fwdB, e.bubble, e.cnt}) begin
            testsFailed++;
            $display("[TB] FAIL %s regs: got A=%b B=%b bub=%b cnt=%h expected A=%b B=%b bub=%b cnt=%h",
                     e.name, FwdA, FwdB, EX_Bubble, StallCnt, e.fwdA, e.fwdB, e.bubble, e.cnt);
         end
      end
   endtask

   task automatic test_alu_chain();
      stimT st[$];
      expT  e;
      doReset();
      st.push_back(aluOp(3,1,2));  sb.push_back(ex("chainAdd", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(aluOp(4,3,3));  sb.push_back(ex("chainSub", 0, 2'b00, 2'b00, 0, 0));
      st.push_back(idleOp());      sb.push_back(ex("chainIdle", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(aluOp(5,1,2));  sb.push_back(ex("gapAdd", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(idleOp());      sb.push_back(ex("gapNop", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(aluOp(6,0,5));  sb.push_back(ex("gapOr", 0, 2'b10, 2'b01, 0, 0));
      st.push_back(idleOp());      sb.push_back(ex("gapIdle", 0, 2'b10, 2'b10, 1, 0));
      foreach (st[k]) begin
         applyStimulus(st[k]);
         @(negedge clk);
         testsRun++;
         if (Stall !== sb[0].stall) begin
            testsFailed++;
            $display("[TB] FAIL %s stall: got %b expected %b", sb[0].name, Stall, sb[0].stall);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         testsRun++;
         if ({FwdA, FwdB, EX_Bubble, StallCnt} !== {e.fwdA, e.fwdB, e.bubble, e.cnt}) begin
            testsFailed++;
            $display("[TB] FAIL %s regs: got A=%b B=%b bub=%b cnt=%h expected A=%b B=%b bub=%b cnt=%h",
                     e.name, FwdA, FwdB, EX_Bubble, StallCnt, e.fwdA, e.fwdB, e.bubble, e.cnt);
         end
      end
   endtask

   task automatic test_load_use();
      stimT st[$];
      expT  e;
      doReset();
      st.push_back(loadOp(2,1));   sb.push_back(ex("luLoad", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(aluOp(7,2,1));  sb.push_back(ex("luStall", 1, 2'b10, 2'b10, 1, 1));
      st.push_back(aluOp(7,2,1));  sb.push_back(ex("luRetry", 0, 2'b01, 2'b10, 0, 1));
      st.push_back(idleOp());      sb.push_back(ex("luIdle", 0, 2'b10, 2'b10, 1, 1));
      st.push_back(loadOp(4,3));   sb.push_back(ex("rtLoad", 0, 2'b10, 2'b10, 0, 1));
      st.push_back(aluOp(9,1,4));  sb.push_back(ex("rtStall", 1, 2'b10, 2'b10, 1, 2));
      st.push_back(aluOp(9,1,4));  sb.push_back(ex("rtRetry", 0, 2'b10, 2'b01, 0, 2));
      st.push_back(loadOp(4,3));   sb.push_back(ex("noRtLoad", 0, 2'b10, 2'b10, 0, 2));
      st.push_back(immOp(4,5));    sb.push_back(ex("noRtUse", 0, 2'b10, 2'b10, 0, 2));
      st.push_back(idleOp());      sb.push_back(ex("noRtIdle", 0, 2'b10, 2'b10, 1, 2));
      foreach (st[k]) begin
         applyStimulus(st[k]);
         @(negedge clk);
         testsRun++;
         if (Stall !== sb[0].stall) begin
            testsFailed++;
            $display("[TB] FAIL %s stall: got %b expected %b", sb[0].name, Stall, sb[0].stall);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         testsRun++;
         if ({FwdA, FwdB, EX_Bubble, StallCnt} !== {e.fwdA, e.fwdB, e.bubble, e.cnt}) begin
            testsFailed++;
            $display("[TB] FAIL %s regs: got A=%b B=%b bub=%b cnt=%h expected A=%b B=%b bub=%b cnt=%h",
                     e.name, FwdA, FwdB, EX_Bubble, StallCnt, e.fwdA, e.fwdB, e.bubble, e.cnt);
         end
      end
   endtask

   task automatic test_priority_and_zero();
      stimT st[$];
      expT  e;
      doReset();
      st.push_back(aluOp(8,1,2));   sb.push_back(ex("dmAdd", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(immOp(8,8));     sb.push_back(ex("dmAddi", 0, 2'b00, 2'b10, 0, 0));
      st.push_back(storeOp(8,9));   sb.push_back(ex("dmStore", 0, 2'b10, 2'b00, 0, 0));
      st.push_back(idleOp());       sb.push_back(ex("dmIdle", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(aluOp(0,1,2));   sb.push_back(ex("zWrite", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(aluOp(6,0,0));   sb.push_back(ex("zRead", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(loadOp(0,1));    sb.push_back(ex("zLoad", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(aluOp(7,0,0));   sb.push_back(ex("zNoStall", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(idleOp());       sb.push_back(ex("zIdle", 0, 2'b10, 2'b10, 1, 0));
      foreach (st[k]) begin
         applyStimulus(st[k]);
         @(negedge clk);
         testsRun++;
         if (Stall !== sb[0].stall) begin
            testsFailed++;
            $display("[TB] FAIL %s stall: got %b expected %b", sb[0].name, Stall, sb[0].stall);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         testsRun++;
         if ({FwdA, FwdB, EX_Bubble, StallCnt} !== {e.fwdA, e.fwdB, e.bubble, e.cnt}) begin
            testsFailed++;
            $display("[TB] FAIL %s regs: got A=%b B=%b bub=%b cnt=%h expected A=%b B=%b bub=%b cnt=%h",
                     e.name, FwdA, FwdB, EX_Bubble, StallCnt, e.fwdA, e.fwdB, e.bubble, e.cnt);
         end
      end
   endtask

   task automatic test_flush_and_reset();
      stimT st[$];
      expT  e;
      stimT s;
      doReset();
      st.push_back(loadOp(2,1));   sb.push_back(ex("flLoad", 0, 2'b10, 2'b10, 0, 0));
      s = aluOp(7,2,1); s.flush = 1'b1;
      st.push_back(s);             sb.push_back(ex("flKill", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(aluOp(7,2,1));  sb.push_back(ex("flAfter", 0, 2'b01, 2'b10, 0, 0));
      s = aluOp(3,1,2); s.flush = 1'b1;
      st.push_back(s);             sb.push_back(ex("flPlain", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(loadOp(2,1));   sb.push_back(ex("rsLoad", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(aluOp(7,2,1));  sb.push_back(ex("rsStall", 1, 2'b10, 2'b10, 1, 1));
      st.push_back(aluOp(7,2,1));  sb.push_back(ex("rsRetry", 0, 2'b01, 2'b10, 0, 1));
      st.push_back(loadOp(2,1));   sb.push_back(ex("rsLoad2", 0, 2'b10, 2'b10, 0, 1));
      s = aluOp(7,2,1); s.rst = 1'b1;
      st.push_back(s);             sb.push_back(ex("rsMidStall", 0, 2'b10, 2'b10, 1, 0));
      st.push_back(aluOp(7,2,1));  sb.push_back(ex("rsAfter", 0, 2'b10, 2'b10, 0, 0));
      st.push_back(idleOp());      sb.push_back(ex("rsIdle", 0, 2'b10, 2'b10, 1, 0));
      foreach (st[k]) begin
         applyStimulus(st[k]);
         @(negedge clk);
         testsRun++;
         if (Stall !== sb[0].stall) begin
            testsFailed++;
            $display("[TB] FAIL %s stall: got %b expected %b", sb[0].name, Stall, sb[0].stall);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         testsRun++;
         if ({FwdA, FwdB, EX_Bubble, StallCnt} !== {e.fwdA, e.fwdB, e.bubble, e.cnt}) begin
            testsFailed++;
            $display("[TB] FAIL %s regs: got A=%b B=%b bub=%b cnt=%h expected A=%b B=%b bub=%b cnt=%h",
                     e.name, FwdA, FwdB, EX_Bubble, StallCnt, e.fwdA, e.fwdB, e.bubble, e.cnt);
         end
      end
   endtask

   // A self-dependent load held in ID stalls on every other cycle.
   task automatic test_saturation();
      stimT ld;
      expT  e;
      doReset();
      ld = loadOp(2,2);
      for (int phase = 0; phase < 2; phase++) begin
         for (int k = 0; k < ((phase == 0) ? 2000 : 130000); k++) begin
            applyStimulus(ld);
            @(posedge clk); #1;
         end
         sb.push_back(ex((phase == 0) ? "satMidA" : "satEndA", 0, 2'b01, 2'b10, 0,
                         (phase == 0) ? 1000 : 65535));
         sb.push_back(ex((phase == 0) ? "satMidB" : "satEndB", 1, 2'b10, 2'b10, 1,
                         (phase == 0) ? 1001 : 65535));
         for (int k = 0; k < 2; k++) begin
            applyStimulus(ld);
            @(negedge clk);
            testsRun++;
            if (Stall !== sb[0].stall) begin
               testsFailed++;
               $display("[TB] FAIL %s stall: got %b expected %b", sb[0].name, Stall, sb[0].stall);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            testsRun++;
            if ({FwdA, FwdB, EX_Bubble, StallCnt} !== {e.fwdA, e.fwdB, e.bubble, e.cnt}) begin
               testsFailed++;
               $display("[TB] FAIL %s regs: got A=%b B=%b bub=%b cnt=%h expected A=%b B=%b bub=%b cnt=%h",
                        e.name, FwdA, FwdB, EX_Bubble, StallCnt, e.fwdA, e.fwdB, e.bubble, e.cnt);
            end
         end
      end
   endtask

   initial begin
      applyStimulus(idleOp());
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_priority_and_zero();
      test_flush_and_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
